// File: rtl/adc5g_spi_cmd_sequencer.sv
// Command queue and sequencer feeding the ADC5G three-wire config mux: buffers
// addr/data commands, issues them one at a time and paces them with a gap.
module adc5g_spi_cmd_sequencer #(
   parameter int DEPTH_LOG2   = 3,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 8191
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_wr_i,
   input  logic [7:0]          cmd_addr_i,
   input  logic [15:0]         cmd_data_i,
   input  logic                flush_i,
   input  logic                clr_err_i,
   output logic                cmd_full_o,
   output logic [DEPTH_LOG2:0] cmd_level_o,
   output logic                config_start_o,
   output logic [7:0]          config_addr_o,
   output logic [15:0]         config_data_o,
   input  logic                config_busy_i,
   output logic                seq_busy_o,
   output logic [15:0]         done_count_o,
   output logic                timeout_o,
   output logic                err_ovf_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [12:0]           TMO_LAST   = 13'(BUSY_TIMEOUT - 1);
   localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [GAP_W-1:0]      GAP_ONE    = GAP_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP
   } state_t;

   state_t                  state_reg, state_next;
   logic [23:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [DEPTH_LOG2:0]     level_reg, level_next;
   logic [7:0]              addr_reg;
   logic [15:0]             data_reg;
   logic                    start_reg;
   logic [15:0]             done_reg;
   logic [12:0]             tmo_cnt_reg, tmo_cnt_next;
   logic [GAP_W-1:0]        gap_cnt_reg, gap_cnt_next;
   logic                    timeout_reg, ovf_reg;
   logic                    full, push, pop, ovf_set, tmo_set, done_inc;

   assign full    = (level_reg == FULL_LEVEL);
   // A concurrent flush swallows the write without flagging an overflow.
   assign push    = cmd_wr_i && !flush_i && !full;
   assign ovf_set = cmd_wr_i && !flush_i && full;

   always_comb begin
      state_next   = state_reg;
      pop          = 1'b0;
      tmo_set      = 1'b0;
      done_inc     = 1'b0;
      tmo_cnt_next = tmo_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (level_reg != '0) begin
               pop        = 1'b1;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_cnt_next = '0;
            state_next   = S_WAIT_HI;
         end
         S_WAIT_HI, S_WAIT_LO: begin
            // Timeout takes priority over a busy edge seen on the same cycle.
            if (tmo_cnt_reg == TMO_LAST) begin
               tmo_set      = 1'b1;
               gap_cnt_next = '0;
               state_next   = S_GAP;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 13'd1;
               if (state_reg == S_WAIT_HI && config_busy_i) begin
                  state_next = S_WAIT_LO;
               end else if (state_reg == S_WAIT_LO && !config_busy_i) begin
                  done_inc     = 1'b1;
                  gap_cnt_next = '0;
                  state_next   = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = S_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + GAP_ONE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      level_next = level_reg;
      if (flush_i) begin
         level_next = '0;
      end else if (push && !pop) begin
         level_next = level_reg + LVL_ONE;
      end else if (pop && !push) begin
         level_next = level_reg - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {cmd_addr_i, cmd_data_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         level_reg   <= '0;
         addr_reg    <= '0;
         data_reg    <= '0;
         start_reg   <= 1'b0;
         done_reg    <= '0;
         tmo_cnt_reg <= '0;
         gap_cnt_reg <= '0;
         timeout_reg <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         level_reg   <= level_next;
         tmo_cnt_reg <= tmo_cnt_next;
         gap_cnt_reg <= gap_cnt_next;
         // Registered start lands one cycle after entering ISSUE, clean of glitches.
         start_reg   <= (state_reg == S_ISSUE);
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (flush_i) begin
            rd_ptr_reg <= wr_ptr_reg;
         end else if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            {addr_reg, data_reg} <= mem[rd_ptr_reg];
         end
         if (done_inc) begin
            done_reg <= done_reg + 16'd1;
         end
         if (tmo_set) begin
            timeout_reg <= 1'b1;
         end else if (clr_err_i) begin
            timeout_reg <= 1'b0;
         end
         if (ovf_set) begin
            ovf_reg <= 1'b1;
         end else if (clr_err_i) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   assign cmd_full_o     = full;
   assign cmd_level_o    = level_reg;
   assign config_start_o = start_reg;
   assign config_addr_o  = addr_reg;
   assign config_data_o  = data_reg;
   assign seq_busy_o     = (state_reg != S_IDLE) || (level_reg != '0);
   assign done_count_o   = done_reg;
   assign timeout_o      = timeout_reg;
   assign err_ovf_o      = ovf_reg;

endmodule

// File: tb/tb_adc5g_spi_cmd_sequencer.sv
// Directed bench for adc5g_spi_cmd_sequencer with a simple busy-pulse model of the mux.
module tb_adc5g_spi_cmd_sequencer;

   localparam int BUSY_LEN = 3800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_wr_i = 1'b0;
   logic [7:0]  cmd_addr_i = '0;
   logic [15:0] cmd_data_i = '0;
   logic        flush_i = 1'b0;
   logic        clr_err_i = 1'b0;
   logic        config_busy_i = 1'b0;
   logic        cmd_full_o;
   logic [3:0]  cmd_level_o;
   logic        config_start_o;
   logic [7:0]  config_addr_o;
   logic [15:0] config_data_o;
   logic        seq_busy_o;
   logic [15:0] done_count_o;
   logic        timeout_o;
   logic        err_ovf_o;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit busy_en = 1'b0;
   bit busy_prev = 1'b0;
   int start_q[$];
   int fall_q[$];
   logic [7:0]  saddr_q[$];
   logic [15:0] sdata_q[$];

   adc5g_spi_cmd_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_wr_i       (cmd_wr_i),
      .cmd_addr_i     (cmd_addr_i),
      .cmd_data_i     (cmd_data_i),
      .flush_i        (flush_i),
      .clr_err_i      (clr_err_i),
      .cmd_full_o     (cmd_full_o),
      .cmd_level_o    (cmd_level_o),
      .config_start_o (config_start_o),
      .config_addr_o  (config_addr_o),
      .config_data_o  (config_data_o),
      .config_busy_i  (config_busy_i),
      .seq_busy_o     (seq_busy_o),
      .done_count_o   (done_count_o),
      .timeout_o      (timeout_o),
      .err_ovf_o      (err_ovf_o)
   );

   always #5 clk = ~clk;

   // Mux model: busy rises two edges after a start is seen and stays high BUSY_LEN cycles.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (busy_en && config_start_o === 1'b1) begin
            @(posedge clk);
            @(posedge clk);
            #2 config_busy_i = 1'b1;
            repeat (BUSY_LEN) @(posedge clk);
            #2 config_busy_i = 1'b0;
         end
      end
   end

   // Advance one edge; cyc names the edge just passed. Logs starts and busy falls.
   task automatic step();
      @(posedge clk);
      #3;
      cyc++;
      if (config_start_o === 1'b1) begin
         start_q.push_back(cyc);
         saddr_q.push_back(config_addr_o);
         sdata_q.push_back(config_data_o);
      end
      if (busy_prev && !config_busy_i) fall_q.push_back(cyc);
      busy_prev = config_busy_i;
   endtask

   task automatic clear_log();
      start_q.delete();
      fall_q.delete();
      saddr_q.delete();
      sdata_q.delete();
   endtask

   task automatic do_reset();
      cmd_wr_i  = 1'b0;
      flush_i   = 1'b0;
      clr_err_i = 1'b0;
      rst_n     = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic push(input logic [7:0] a, input logic [15:0] d);
      cmd_wr_i   = 1'b1;
      cmd_addr_i = a;
      cmd_data_i = d;
      step();
      cmd_wr_i = 1'b0;
      $display("[%0d] push addr=%02h data=%04h level=%0d full=%0b ovf=%0b",
               cyc, a, d, cmd_level_o, cmd_full_o, err_ovf_o);
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (seq_busy_o && n < limit) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      step();
      step();
      n_cmp++;
      if ({cmd_full_o, cmd_level_o, config_start_o, config_addr_o, config_data_o, seq_busy_o,
           done_count_o, timeout_o, err_ovf_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_hold: outputs %h required all zero",
                  {cmd_level_o, config_addr_o, config_data_o, done_count_o});
      end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if ({cmd_level_o, config_start_o, seq_busy_o, done_count_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_release: level=%0d start=%0b seq_busy=%0b done=%0d required 0",
                  cmd_level_o, config_start_o, seq_busy_o, done_count_o);
      end
   endtask

   task automatic test_single();
      int k, n, unstable, s0, gap;
      busy_en = 1'b1;
      do_reset();
      clear_log();
      push(8'h81, 16'h0308);
      k = cyc;
      n_cmp++;
      if (cmd_level_o !== 4'd1) begin
         n_bad++;
         $display("FAIL single_level: got %0d required 1", cmd_level_o);
      end
      n = 0;
      unstable = 0;
      while (seq_busy_o && n < 6000) begin
         step();
         n++;
         if (config_addr_o !== 8'h81 || config_data_o !== 16'h0308) unstable++;
      end
      n_cmp++;
      if (seq_busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL single_idle: seq_busy still %0b after %0d cycles, required 0", seq_busy_o, n);
      end
      n_cmp++;
      if (unstable != 0) begin
         n_bad++;
         $display("FAIL single_stable: addr/data off 81/0308 on %0d cycles, required 0", unstable);
      end
      s0 = (start_q.size() > 0) ? start_q[0] - k : -1;
      n_cmp++;
      if (start_q.size() != 1 || s0 != 2) begin
         n_bad++;
         $display("FAIL single_start: %0d start cycles, first at push+%0d, required 1 at push+2",
                  start_q.size(), s0);
      end
      gap = (fall_q.size() > 0) ? cyc - fall_q[0] : -1;
      n_cmp++;
      if (fall_q.size() != 1 || gap != 17) begin
         n_bad++;
         $display("FAIL single_gap: idle %0d cycles after busy fall, required 17", gap);
      end
      n_cmp++;
      if (done_count_o !== 16'd1) begin
         n_bad++;
         $display("FAIL single_done: got %0d required 1", done_count_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ea [3] = '{8'h81, 8'h82, 8'h83};
      logic [15:0] ed [3] = '{16'h0308, 16'h1234, 16'hABCD};
      int d;
      busy_en = 1'b1;
      do_reset();
      clear_log();
      for (int i = 0; i < 3; i++) push(ea[i], ed[i]);
      wait_idle(15000);
      n_cmp++;
      if (start_q.size() != 3 || fall_q.size() != 3) begin
         n_bad++;
         $display("FAIL b2b_count: starts=%0d falls=%0d required 3/3", start_q.size(), fall_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < start_q.size()) begin
            n_cmp++;
            if (saddr_q[i] !== ea[i] || sdata_q[i] !== ed[i]) begin
               n_bad++;
               $display("FAIL b2b_order[%0d]: got %02h/%04h required %02h/%04h",
                        i, saddr_q[i], sdata_q[i], ea[i], ed[i]);
            end
         end
      end
      // Busy fall -> WAIT_LO sample (1) + 16 gap cycles + IDLE pop (1) + ISSUE (1).
      for (int i = 1; i < 3; i++) begin
         if (i < start_q.size() && i <= fall_q.size()) begin
            d = start_q[i] - fall_q[i-1];
            n_cmp++;
            if (d != 19) begin
               n_bad++;
               $display("FAIL b2b_spacing[%0d]: start %0d cycles after busy fall, required 19", i, d);
            end
         end
      end
      n_cmp++;
      if (done_count_o !== 16'd3) begin
         n_bad++;
         $display("FAIL b2b_done: got %0d required 3", done_count_o);
      end
   endtask

   task automatic test_overflow();
      int n;
      busy_en = 1'b0;
      do_reset();
      clear_log();
      for (int i = 0; i < 9; i++) push(8'(8'h10 + i), 16'(16'h1000 + i));
      n_cmp++;
      if (cmd_level_o !== 4'd8 || cmd_full_o !== 1'b1 || err_ovf_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_fill: level=%0d full=%0b ovf=%0b required 8/1/0",
                  cmd_level_o, cmd_full_o, err_ovf_o);
      end
      push(8'hEE, 16'hEEEE);
      n_cmp++;
      if (err_ovf_o !== 1'b1 || cmd_level_o !== 4'd8) begin
         n_bad++;
         $display("FAIL ovf_set: ovf=%0b level=%0d required 1/8", err_ovf_o, cmd_level_o);
      end
      clr_err_i = 1'b1;
      step();
      clr_err_i = 1'b0;
      n_cmp++;
      if (err_ovf_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_clear: got %0b required 0", err_ovf_o);
      end
      cmd_wr_i  = 1'b1;
      clr_err_i = 1'b1;
      step();
      cmd_wr_i  = 1'b0;
      clr_err_i = 1'b0;
      n_cmp++;
      if (err_ovf_o !== 1'b1) begin
         n_bad++;
         $display("FAIL ovf_set_wins: got %0b required 1", err_ovf_o);
      end
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      n_cmp++;
      if (cmd_level_o !== 4'd0 || cmd_full_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_flush: level=%0d full=%0b required 0/0", cmd_level_o, cmd_full_o);
      end
      n = 0;
      while (timeout_o !== 1'b1 && n < 9000) begin
         step();
         n++;
      end
      n_cmp++;
      if (timeout_o !== 1'b1 || done_count_o !== 16'd0) begin
         n_bad++;
         $display("FAIL ovf_timeout: timeout=%0b done=%0d required 1/0", timeout_o, done_count_o);
      end
      clr_err_i = 1'b1;
      step();
      clr_err_i = 1'b0;
      n_cmp++;
      if (timeout_o !== 1'b0 || err_ovf_o !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: timeout=%0b ovf=%0b required 0/0", timeout_o, err_ovf_o);
      end
      wait_idle(100);
      n_cmp++;
      if (start_q.size() != 1 || seq_busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ovf_starts: %0d starts seq_busy=%0b required 1/0", start_q.size(), seq_busy_o);
      end
   endtask

   task automatic test_timeout();
      int k, n;
      busy_en = 1'b0;
      do_reset();
      clear_log();
      push(8'h55, 16'h5555);
      k = cyc;
      n = 0;
      while (timeout_o !== 1'b1 && n < 9000) begin
         step();
         n++;
      end
      n_cmp++;
      if (timeout_o !== 1'b1 || cyc - k != 8193) begin
         n_bad++;
         $display("FAIL tmo_time: timeout=%0b at push+%0d required 1 at push+8193", timeout_o, cyc - k);
      end
      n_cmp++;
      if (done_count_o !== 16'd0) begin
         n_bad++;
         $display("FAIL tmo_done: got %0d required 0", done_count_o);
      end
      wait_idle(100);
      n_cmp++;
      if (seq_busy_o !== 1'b0 || cyc - k != 8209 || timeout_o !== 1'b1) begin
         n_bad++;
         $display("FAIL tmo_idle: idle at push+%0d timeout=%0b required push+8209 and 1",
                  cyc - k, timeout_o);
      end
   endtask

   task automatic test_flush();
      int n;
      busy_en = 1'b1;
      do_reset();
      clear_log();
      for (int i = 0; i < 4; i++) push(8'(8'h91 + i), 16'(16'h9100 + i));
      n_cmp++;
      if (cmd_level_o !== 4'd3) begin
         n_bad++;
         $display("FAIL flush_pre_level: got %0d required 3", cmd_level_o);
      end
      n = 0;
      while (config_busy_i !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      cmd_wr_i   = 1'b1;
      cmd_addr_i = 8'hF0;
      cmd_data_i = 16'hF0F0;
      flush_i    = 1'b1;
      step();
      cmd_wr_i = 1'b0;
      flush_i  = 1'b0;
      n_cmp++;
      if (cmd_level_o !== 4'd0 || err_ovf_o !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_level: level=%0d ovf=%0b required 0/0", cmd_level_o, err_ovf_o);
      end
      wait_idle(6000);
      n_cmp++;
      if (done_count_o !== 16'd1 || start_q.size() != 1 || seq_busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_complete: done=%0d starts=%0d seq_busy=%0b required 1/1/0",
                  done_count_o, start_q.size(), seq_busy_o);
      end
      if (saddr_q.size() > 0) begin
         n_cmp++;
         if (saddr_q[0] !== 8'h91) begin
            n_bad++;
            $display("FAIL flush_inflight_addr: got %02h required 91", saddr_q[0]);
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      busy_en = 1'b1;
      do_reset();
      clear_log();
      for (int i = 0; i < 3; i++) push(8'(8'hA1 + i), 16'(16'hA100 + i));
      n = 0;
      while (config_busy_i !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      repeat (5) step();
      n_cmp++;
      if (cmd_level_o !== 4'd2 || config_addr_o !== 8'hA1) begin
         n_bad++;
         $display("FAIL rst_pre: level=%0d addr=%02h required 2/A1", cmd_level_o, config_addr_o);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cmd_full_o, cmd_level_o, config_start_o, config_addr_o, config_data_o, seq_busy_o,
           done_count_o, timeout_o, err_ovf_o} !== '0) begin
         n_bad++;
         $display("FAIL rst_async: level=%0d addr=%02h data=%04h seq_busy=%0b required all zero",
                  cmd_level_o, config_addr_o, config_data_o, seq_busy_o);
      end
      step();
      step();
      rst_n = 1'b1;
      clear_log();
      repeat (40) step();
      n_cmp++;
      if (start_q.size() != 0 || cmd_level_o !== 4'd0 || seq_busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_after: starts=%0d level=%0d seq_busy=%0b required 0/0/0",
                  start_q.size(), cmd_level_o, seq_busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
